// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between requesters A and B.
// Each grant produces one registered write cycle: one-hot enable, common data bus, ack pulse.
module regfile_write_arbiter #(
  parameter int WORD_LENGTH  = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int NUM_REGS     = 32,
  parameter int PROTECT_ZERO = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   Req_A,
  input  logic [ADDR_WIDTH-1:0]  Addr_A,
  input  logic [WORD_LENGTH-1:0] Data_A,
  input  logic                   Req_B,
  input  logic [ADDR_WIDTH-1:0]  Addr_B,
  input  logic [WORD_LENGTH-1:0] Data_B,
  output logic                   Ack_A,
  output logic                   Ack_B,
  output logic [NUM_REGS-1:0]    Reg_Enable,
  output logic [WORD_LENGTH-1:0] Write_Data,
  output logic                   Addr_Error,
  output logic                   Busy,
  output logic                   dbg_state
);

  // Handshake: a requester raises Req with Addr/Data stable and holds them until it
  // sees its Ack pulse; the write is issued in the Ack cycle. A Req still high in the
  // IDLE cycle after the Ack is treated as a brand-new request.

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH:0] NUM_REGS_W = (ADDR_WIDTH + 1)'(NUM_REGS);

  state_t                 r_state;
  state_t                 w_next_state;
  logic                   r_last_b;
  logic                   w_grant_a;
  logic                   w_grant_b;
  logic [ADDR_WIDTH-1:0]  w_addr;
  logic [WORD_LENGTH-1:0] w_data;
  logic                   w_in_range;
  logic                   w_zero_blocked;
  logic [NUM_REGS-1:0]    w_enable;

  // Arbitration only happens in IDLE; on a tie the side not granted last wins.
  always_comb begin
    w_next_state = r_state;
    w_grant_a    = 1'b0;
    w_grant_b    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Req_A && (!Req_B || r_last_b)) begin
          w_grant_a = 1'b1;
        end else if (Req_B) begin
          w_grant_b = 1'b1;
        end
        if (w_grant_a || w_grant_b) begin
          w_next_state = S_WRITE;
        end
      end
      S_WRITE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_addr         = w_grant_b ? Addr_B : Addr_A;
    w_data         = w_grant_b ? Data_B : Data_A;
    w_in_range     = ({1'b0, w_addr} < NUM_REGS_W);
    w_zero_blocked = (PROTECT_ZERO != 0) && (w_addr == '0);
    w_enable       = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_in_range && !w_zero_blocked && (w_addr == ADDR_WIDTH'(i))) begin
        w_enable[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Pointer resets to "last granted B" so A wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_b   <= 1'b1;
      Ack_A      <= 1'b0;
      Ack_B      <= 1'b0;
      Busy       <= 1'b0;
      Addr_Error <= 1'b0;
      Reg_Enable <= '0;
      Write_Data <= '0;
    end else begin
      Ack_A      <= w_grant_a;
      Ack_B      <= w_grant_b;
      Busy       <= (w_next_state == S_WRITE);
      Addr_Error <= (w_grant_a || w_grant_b) && !w_in_range;
      Reg_Enable <= (w_grant_a || w_grant_b) ? w_enable : '0;
      if (w_grant_a || w_grant_b) begin
        Write_Data <= w_data;
        r_last_b   <= w_grant_b;
      end
    end
  end

  assign dbg_state = logic'(r_state);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus random traffic against a
// transaction-level reference model; a 16-register instance shares the stimulus.
module tb_regfile_write_arbiter;

  localparam int W  = 32;
  localparam int AW = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic          req_a, req_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [W-1:0]  data_a, data_b;

  logic          ack_a, ack_b, err, busy, dbg;
  logic [31:0]   en;
  logic [W-1:0]  wdata;
  logic          ack_a16, ack_b16, err16, busy16, dbg16;
  logic [15:0]   en16;
  logic [W-1:0]  wdata16;

  regfile_write_arbiter #(.WORD_LENGTH(W), .ADDR_WIDTH(AW), .NUM_REGS(32), .PROTECT_ZERO(1)) dut (
    .clk(clk), .reset(rst_n),
    .Req_A(req_a), .Addr_A(addr_a), .Data_A(data_a),
    .Req_B(req_b), .Addr_B(addr_b), .Data_B(data_b),
    .Ack_A(ack_a), .Ack_B(ack_b), .Reg_Enable(en), .Write_Data(wdata),
    .Addr_Error(err), .Busy(busy), .dbg_state(dbg)
  );

  regfile_write_arbiter #(.WORD_LENGTH(W), .ADDR_WIDTH(AW), .NUM_REGS(16), .PROTECT_ZERO(1)) dut16 (
    .clk(clk), .reset(rst_n),
    .Req_A(req_a), .Addr_A(addr_a), .Data_A(data_a),
    .Req_B(req_b), .Addr_B(addr_b), .Data_B(data_b),
    .Ack_A(ack_a16), .Ack_B(ack_b16), .Reg_Enable(en16), .Write_Data(wdata16),
    .Addr_Error(err16), .Busy(busy16), .dbg_state(dbg16)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- reference model ----------------
  // Transaction view: a grant occupies one write cycle, then one idle cycle follows.
  logic        m_busy, m_last_b, m_ack_a, m_ack_b, m_err, m_err16;
  logic [31:0] m_en;
  logic [15:0] m_en16;
  logic [W-1:0] m_data;

  always @(posedge clk or negedge rst_n) begin
    int unsigned a;
    logic win_b;
    if (!rst_n) begin
      m_busy = 0; m_last_b = 1; m_ack_a = 0; m_ack_b = 0; m_err = 0; m_err16 = 0;
      m_en = 0; m_en16 = 0; m_data = 0;
    end else if (m_busy) begin
      m_busy = 0; m_ack_a = 0; m_ack_b = 0; m_err = 0; m_err16 = 0; m_en = 0; m_en16 = 0;
    end else if (req_a || req_b) begin
      if (req_a && req_b) win_b = !m_last_b;
      else                win_b = req_b;
      m_last_b = win_b;
      a        = win_b ? int'(addr_b) : int'(addr_a);
      m_data   = win_b ? data_b : data_a;
      m_ack_a  = !win_b;
      m_ack_b  = win_b;
      m_busy   = 1;
      m_en     = (a != 0 && a < 32) ? (32'd1 << a) : 32'd0;
      m_en16   = (a != 0 && a < 16) ? (16'd1 << a) : 16'd0;
      m_err    = (a >= 32);
      m_err16  = (a >= 16);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge clk);
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic quiet();
    req_a = 0; req_b = 0;
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [AW-1:0] a;
    logic [W-1:0]  d;
    a = AW'($urandom_range(1, 31));
    d = $urandom();
    rst_n = 1; req_a = 0; req_b = 0; addr_a = 0; addr_b = 0; data_a = 0; data_b = 0;
    #1 rst_n = 0;
    req_a = 1; addr_a = a; data_a = d;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({ack_a, ack_b, busy, err, dbg, en, wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ack=%b%b busy=%b err=%b en=%h wd=%h want all 0",
               ack_a, ack_b, busy, err, en, wdata);
    end
    n_cmp++;
    if ({ack_a16, ack_b16, busy16, err16, dbg16, en16, wdata16} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs16: got ack=%b%b busy=%b err=%b en=%h want all 0",
               ack_a16, ack_b16, busy16, err16, en16);
    end
    rst_n = 1;
    @(negedge clk);
    n_cmp++;
    if ({ack_a, ack_b, busy, err, en, wdata} !== {1'b1, 1'b0, 1'b1, 1'b0, 32'd1 << a, d}) begin
      n_fail++;
      $display("FAIL reset_first_grant: got ack=%b%b busy=%b err=%b en=%h wd=%h want ack=10 busy=1 err=0 en=%h wd=%h",
               ack_a, ack_b, busy, err, en, wdata, 32'd1 << a, d);
    end
    n_cmp++;
    if ({ack_a16, en16, err16} !== {1'b1, (a < 16) ? (16'd1 << a) : 16'd0, a >= 16}) begin
      n_fail++;
      $display("FAIL reset_first_grant16: got ack=%b en=%h err=%b for addr %0d", ack_a16, en16, err16, a);
    end
    req_a = 0;
    @(negedge clk);
    n_cmp++;
    if ({ack_a, ack_b, busy, err, en, wdata} !== {36'd0, d}) begin
      n_fail++;
      $display("FAIL reset_after_write: got ack=%b%b busy=%b err=%b en=%h wd=%h want 0s, wd=%h",
               ack_a, ack_b, busy, err, en, wdata, d);
    end
  endtask

  task automatic test_single_write();
    quiet();
    req_a = 1; addr_a = 5; data_a = 32'd15;
    @(negedge clk);
    n_cmp++;
    if ({ack_a, ack_b, busy, err, en, wdata} !== {1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'd15}) begin
      n_fail++;
      $display("FAIL single_write: got ack=%b%b busy=%b err=%b en=%h wd=%h want ack=10 busy=1 en=00000020 wd=f",
               ack_a, ack_b, busy, err, en, wdata);
    end
    req_a = 0;
    @(negedge clk);
    n_cmp++;
    if ({ack_a, ack_b, busy, err, en} !== '0) begin
      n_fail++;
      $display("FAIL single_write_clear: got ack=%b%b busy=%b err=%b en=%h want 0", ack_a, ack_b, busy, err, en);
    end
  endtask

  task automatic test_zero_protect();
    quiet();
    req_b = 1; addr_b = 0; data_b = 32'hFFFF_FFFF;
    @(negedge clk);
    n_cmp++;
    if ({ack_a, ack_b, busy, err, en, wdata} !== {1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 32'hFFFF_FFFF}) begin
      n_fail++;
      $display("FAIL zero_protect: got ack=%b%b busy=%b err=%b en=%h wd=%h want ack=01 busy=1 err=0 en=0 wd=ffffffff",
               ack_a, ack_b, busy, err, en, wdata);
    end
    n_cmp++;
    if ({ack_b16, err16, en16} !== {1'b1, 1'b0, 16'd0}) begin
      n_fail++;
      $display("FAIL zero_protect16: got ack_b=%b err=%b en=%h want 1 0 0", ack_b16, err16, en16);
    end
    req_b = 0;
    @(negedge clk);
  endtask

  task automatic test_out_of_range();
    logic [W-1:0] d;
    d = $urandom();
    quiet();
    req_a = 1; addr_a = 20; data_a = d;
    @(negedge clk);
    n_cmp++;
    if ({ack_a16, busy16, err16, en16, wdata16} !== {1'b1, 1'b1, 1'b1, 16'd0, d}) begin
      n_fail++;
      $display("FAIL out_of_range16: got ack=%b busy=%b err=%b en=%h wd=%h want 1 1 1 0 %h",
               ack_a16, busy16, err16, en16, wdata16, d);
    end
    n_cmp++;
    if ({ack_a, err, en} !== {1'b1, 1'b0, 32'h0010_0000}) begin
      n_fail++;
      $display("FAIL in_range32_addr20: got ack=%b err=%b en=%h want 1 0 00100000", ack_a, err, en);
    end
    req_a = 0;
    @(negedge clk);
    n_cmp++;
    if ({ack_a16, err16, en16} !== '0) begin
      n_fail++;
      $display("FAIL out_of_range16_pulse: got ack=%b err=%b en=%h want 0", ack_a16, err16, en16);
    end
  endtask

  task automatic test_contention();
    int  k;
    logic exp_is_a;
    logic [W-1:0] e;
    apply_reset();
    req_a = 1; addr_a = 3; data_a = $urandom();
    req_b = 1; addr_b = 7; data_b = $urandom();
    exp_q.push_back(data_a); exp_q.push_back(data_b);
    exp_q.push_back(data_a); exp_q.push_back(data_b);
    k = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      n_cmp++;
      if (ack_a && ack_b) begin
        n_fail++;
        $display("FAIL contention_both_ack: cycle %0d got both acks high, want at most one", i);
      end
      n_cmp++;
      if ((ack_a | ack_b) !== (i % 2 == 1)) begin
        n_fail++;
        $display("FAIL contention_spacing: cycle %0d got ack=%b want %b", i, ack_a | ack_b, i % 2 == 1);
      end
      if (ack_a || ack_b) begin
        exp_is_a = (k % 2 == 0);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        n_cmp++;
        if ({ack_a, en, wdata} !== {exp_is_a, exp_is_a ? 32'h8 : 32'h80, e}) begin
          n_fail++;
          $display("FAIL contention_grant%0d: got ack_a=%b en=%h wd=%h want ack_a=%b en=%h wd=%h",
                   k, ack_a, en, wdata, exp_is_a, exp_is_a ? 32'h8 : 32'h80, e);
        end
        k++;
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL contention_count: got %0d grants want 4", k);
      exp_q.delete();
    end
    quiet();
  endtask

  task automatic test_reset_during_write();
    bit seen;
    req_a = 1; addr_a = 9;  data_a = $urandom();
    req_b = 1; addr_b = 12; data_b = $urandom();
    seen = 0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      if (busy) seen = 1;
    end
    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("FAIL rst_mid_write_busy: got busy=%b within 6 cycles want 1", busy);
    end else begin
      #2 rst_n = 0;
      #1;
      n_cmp++;
      if ({ack_a, ack_b, busy, err, en, wdata} !== '0 || {ack_a16, ack_b16, busy16, en16} !== '0) begin
        n_fail++;
        $display("FAIL rst_mid_write_clear: got ack=%b%b busy=%b en=%h wd=%h en16=%h want 0",
                 ack_a, ack_b, busy, en, wdata, en16);
      end
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      n_cmp++;
      if ({ack_a, ack_b, en, wdata} !== {1'b1, 1'b0, 32'h0000_0200, data_a}) begin
        n_fail++;
        $display("FAIL rst_mid_write_regrant: got ack=%b%b en=%h wd=%h want ack=10 en=00000200 wd=%h",
                 ack_a, ack_b, en, wdata, data_a);
      end
    end
    quiet();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({ack_a, ack_b, busy, err, en, wdata} !== {m_ack_a, m_ack_b, m_busy, m_err, m_en, m_data}) begin
        n_fail++;
        $display("FAIL random32 cyc %0d: got ack=%b%b busy=%b err=%b en=%h wd=%h want ack=%b%b busy=%b err=%b en=%h wd=%h",
                 i, ack_a, ack_b, busy, err, en, wdata, m_ack_a, m_ack_b, m_busy, m_err, m_en, m_data);
      end
      n_cmp++;
      if ({ack_a16, ack_b16, busy16, err16, en16, wdata16} !== {m_ack_a, m_ack_b, m_busy, m_err16, m_en16, m_data}) begin
        n_fail++;
        $display("FAIL random16 cyc %0d: got ack=%b%b busy=%b err=%b en=%h wd=%h want ack=%b%b busy=%b err=%b en=%h wd=%h",
                 i, ack_a16, ack_b16, busy16, err16, en16, wdata16, m_ack_a, m_ack_b, m_busy, m_err16, m_en16, m_data);
      end
      n_cmp++;
      if ($countones(en) > 1 || (ack_a && ack_b)) begin
        n_fail++;
        $display("FAIL random_onehot cyc %0d: got en=%h ack=%b%b want <=1 bit and one ack", i, en, ack_a, ack_b);
      end
      if (!req_a || ack_a) begin
        req_a  = ($urandom_range(0, 2) != 0);
        addr_a = AW'($urandom_range(0, 31));
        data_a = $urandom();
      end
      if (!req_b || ack_b) begin
        req_b  = ($urandom_range(0, 2) != 0);
        addr_b = AW'($urandom_range(0, 31));
        data_b = $urandom();
      end
    end
    quiet();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_write();
    test_zero_protect();
    test_out_of_range();
    test_contention();
    test_reset_during_write();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write path of the register file between two requesters, A and B.
- The register file is built from per-word enabled registers.
- Each write cycle, the block drives a one-hot enable vector (one bit per register's enable input) and a common data bus (to every register's Data_Input).
- Arbitration is round-robin, with a req/ack handshake and a two-state FSM.
- Sits between the datapath write sources and the register array.

Parameters:
- WORD_LENGTH, 32, width of register data.
- ADDR_WIDTH, 5, width of the write address.
- NUM_REGS, 32, number of registers driven; must satisfy NUM_REGS <= 2^ADDR_WIDTH.
- PROTECT_ZERO, 1, when 1, writes to address 0 are acked but never enable register 0.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- Req_A  input  1  requester A write request; held high until Ack_A.
- Addr_A  input  ADDR_WIDTH  requester A target register; stable while Req_A is high.
- Data_A  input  WORD_LENGTH  requester A write data; stable while Req_A is high.
- Req_B  input  1  requester B write request.
- Addr_B  input  ADDR_WIDTH  requester B target register.
- Data_B  input  WORD_LENGTH  requester B write data.
- Ack_A  output  1  one-cycle pulse: A's write is issued this cycle.
- Ack_B  output  1  one-cycle pulse: B's write is issued this cycle.
- Reg_Enable  output  NUM_REGS  one-hot register enables; all zero when no write.
- Write_Data  output  WORD_LENGTH  data bus to every register.
- Addr_Error  output  1  one-cycle pulse: granted address >= NUM_REGS.
- Busy  output  1  high while FSM is in WRITE.

Behaviour:
- Reset (reset=0, asynchronous, immediate) forces:
  - FSM=IDLE.
  - Ack_A, Ack_B, Addr_Error, Busy = 0.
  - Reg_Enable = 0 and Write_Data = 0.
  - Priority pointer = "last granted B", so A wins the first tie.
- All outputs are registered. No combinational path from inputs to outputs.
- FSM state IDLE, evaluated at each rising edge:
  - No request: stay IDLE; all outputs 0 (Write_Data holds its last value).
  - Exactly one of Req_A/Req_B high: grant it.
  - Both high: grant the requester not granted last. Update the pointer to the winner.
  - On grant, transition to WRITE and register the following:
    - Ack of the winner = 1; Busy = 1.
    - Write_Data = winner's data.
    - Reg_Enable bit [winner addr] = 1, if addr < NUM_REGS and not (PROTECT_ZERO=1 and addr=0). Otherwise Reg_Enable = 0.
    - Addr_Error = 1 iff addr >= NUM_REGS. Address 0 under protection is not an error.
- FSM state WRITE (lasts exactly one cycle):
  - Outputs above are valid for this cycle. The register array captures at the next edge.
  - At the next edge, unconditionally return to IDLE and clear Ack/Reg_Enable/Addr_Error/Busy.
  - No arbitration is performed in WRITE. This lets the requester drop Req after seeing Ack, so a still-high Req is never double-granted.
- Latency and throughput:
  - Request sampled at edge N gives Ack/Reg_Enable high for the cycle after edge N.
  - Maximum rate is one write per 2 cycles.
- Fairness: under continuous requests from both sides, grants strictly alternate A,B,A,B.
- A requester that holds Req after its Ack re-arbitrates in the next IDLE cycle as a new request. Under contention it then loses to the other side.
- Reg_Enable has at most one bit set in any cycle. Ack_A and Ack_B are never both high.
- Reset asserted mid-WRITE: outputs clear immediately and that write is not performed. Requesters keep Req high and are re-served after reset release, A first on a tie.
- Address wrap: none. Only the low ADDR_WIDTH bits are used; out-of-range values are flagged, not wrapped.

Test Plan:
- Reset: hold reset=0 with Req_A=1 -> all outputs 0. Release -> Ack_A=1, Reg_Enable=32'h0000_0001<<Addr_A, Write_Data=Data_A one cycle after the first sampling edge.
- Single write: Req_A=1, Addr_A=5, Data_A=32'd15 -> next cycle Ack_A=1, Reg_Enable=32'h0000_0020, Write_Data=15, Busy=1. Following cycle all 0.
- Contention: Req_A and Req_B both held high with Addr_A=3, Addr_B=7 for 8 cycles -> grants A,B,A,B at 2-cycle spacing. Reg_Enable alternates 32'h8 / 32'h80. Never both Acks high.
- Zero protection: Req_B=1, Addr_B=0, Data_B=32'hFFFF_FFFF, PROTECT_ZERO=1 -> Ack_B=1, Reg_Enable=0, Addr_Error=0.
- Out of range: NUM_REGS=16, Req_A with Addr_A=20 -> Ack_A=1, Reg_Enable=0, Addr_Error=1 for one cycle.
- Reset during WRITE: assert reset=0 mid-cycle while Busy=1 -> Reg_Enable and Ack drop immediately. After release with both Reqs high, A is granted first.
